// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush and bubble gating. The head entry is always held in main_r;
// skid_r only holds the second entry when the stage is FULL.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int CTRL_W  = 4,
    parameter int INSTR_W = 32,
    parameter int SKID    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_wdata,
    input  logic [REG_W-1:0]   in_wreg,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [REG_W-1:0]   in_rt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_alu,
    output logic [DATA_W-1:0]  out_wdata,
    output logic [REG_W-1:0]   out_wreg,
    output logic [REG_W-1:0]   out_rt,
    output logic [INSTR_W-1:0] out_instr,
    output logic               hz_regwrite,
    output logic               hz_mem_to_reg,
    output logic               hz_mem_write,
    output logic [1:0]         occupancy
);

    // Payload layout (LSB first): rt, instr, wreg, wdata, alu, ctrl
    localparam int OFF_INSTR = REG_W;
    localparam int OFF_WREG  = OFF_INSTR + INSTR_W;
    localparam int OFF_WDATA = OFF_WREG + REG_W;
    localparam int OFF_ALU   = OFF_WDATA + DATA_W;
    localparam int OFF_CTRL  = OFF_ALU + DATA_W;
    localparam int PAY_W     = OFF_CTRL + CTRL_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PAY_W-1:0]   main_r;
    logic [PAY_W-1:0]   skid_r;
    logic [PAY_W-1:0]   in_pay_s;
    logic               accept_s;
    logic               pop_s;
    logic               main_ld_in_s;
    logic               main_ld_skid_s;
    logic               skid_ld_s;
    logic               valid_s;

    assign in_pay_s = {in_ctrl, in_alu, in_wdata, in_wreg, in_instr, in_rt};
    assign valid_s  = (state_r != ST_EMPTY);
    assign accept_s = in_valid & in_ready & ~flush & ~rst;
    assign pop_s    = valid_s & out_ready;

    // State register: reset and flush both return the stage to EMPTY
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else if (flush) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath load decode from the handshake events
    always_comb begin
        state_nxt_s    = state_r;
        main_ld_in_s   = 1'b0;
        main_ld_skid_s = 1'b0;
        skid_ld_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s  = ST_ONE;
                    main_ld_in_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && pop_s) begin
                    state_nxt_s  = ST_ONE;
                    main_ld_in_s = 1'b1;
                end else if (accept_s) begin
                    // Only reachable with the skid buffer: with SKID=0 an
                    // accept while ONE implies out_ready, hence a pop.
                    state_nxt_s  = ST_FULL;
                    skid_ld_s    = 1'b1;
                end else if (pop_s) begin
                    state_nxt_s  = ST_EMPTY;
                end else begin
                    state_nxt_s  = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_nxt_s    = ST_ONE;
                    main_ld_skid_s = 1'b1;
                end else begin
                    state_nxt_s    = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Payload registers: main holds the head, skid holds the second entry
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= {PAY_W{1'b0}};
            skid_r <= {PAY_W{1'b0}};
        end else if (flush) begin
            main_r <= main_r;
            skid_r <= skid_r;
        end else begin
            if (main_ld_in_s) begin
                main_r <= in_pay_s;
            end else if (main_ld_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (skid_ld_s) begin
                skid_r <= in_pay_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    // Output decode: ready, occupancy and bubble gating of control/instr
    always_comb begin
        out_valid = valid_s;
        if (SKID != 0) begin
            in_ready = (state_r != ST_FULL);
        end else begin
            in_ready = ~valid_s | out_ready;
        end
        case (state_r)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
        out_alu   = main_r[OFF_ALU +: DATA_W];
        out_wdata = main_r[OFF_WDATA +: DATA_W];
        out_wreg  = main_r[OFF_WREG +: REG_W];
        out_rt    = main_r[REG_W-1:0];
        if (valid_s) begin
            out_ctrl  = main_r[OFF_CTRL +: CTRL_W];
            out_instr = main_r[OFF_INSTR +: INSTR_W];
        end else begin
            out_ctrl  = {CTRL_W{1'b0}};
            out_instr = {INSTR_W{1'b0}};
        end
        hz_regwrite   = out_ctrl[1];
        hz_mem_to_reg = out_ctrl[2];
        hz_mem_write  = out_ctrl[3];
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. Two builds (SKID=1 and SKID=0)
// share all inputs except nothing; each is checked against a queue model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic [31:0] instr;
        logic [4:0]  rt;
    } pay_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [31:0] alu;
        logic [3:0]  ctrl;
        logic        ev;
        logic [1:0]  eocc;
        logic        eir;
        logic        chk_alu;
        logic [31:0] ealu;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    pay_t        drv = '0;

    logic        ir1, ov1, hrw1, hm2r1, hmw1;
    logic [3:0]  ctrl1;
    logic [31:0] alu1, wdata1, instr1;
    logic [4:0]  wreg1, rt1;
    logic [1:0]  occ1;
    logic        ir0, ov0, hrw0, hm2r0, hmw0;
    logic [3:0]  ctrl0;
    logic [31:0] alu0, wdata0, instr0;
    logic [4:0]  wreg0, rt0;
    logic [1:0]  occ0;

    pay_t q1[$];
    pay_t q0[$];
    int   n_pass = 0;
    int   n_total = 0;
    vec_t vt[19];

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_ctrl(drv.ctrl), .in_alu(drv.alu), .in_wdata(drv.wdata), .in_wreg(drv.wreg),
        .in_instr(drv.instr), .in_rt(drv.rt), .out_valid(ov1), .out_ready(out_ready),
        .out_ctrl(ctrl1), .out_alu(alu1), .out_wdata(wdata1), .out_wreg(wreg1),
        .out_rt(rt1), .out_instr(instr1), .hz_regwrite(hrw1), .hz_mem_to_reg(hm2r1),
        .hz_mem_write(hmw1), .occupancy(occ1)
    );

    pipe_stage_reg #(.SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
        .in_ctrl(drv.ctrl), .in_alu(drv.alu), .in_wdata(drv.wdata), .in_wreg(drv.wreg),
        .in_instr(drv.instr), .in_rt(drv.rt), .out_valid(ov0), .out_ready(out_ready),
        .out_ctrl(ctrl0), .out_alu(alu0), .out_wdata(wdata0), .out_wreg(wreg0),
        .out_rt(rt0), .out_instr(instr0), .hz_regwrite(hrw0), .hz_mem_to_reg(hm2r0),
        .hz_mem_write(hmw0), .occupancy(occ0)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic pay_t mkpay(input logic [31:0] alu, input logic [3:0] ctrl);
        pay_t p;
        p.ctrl  = ctrl;
        p.alu   = alu;
        p.wdata = alu ^ 32'h5a5a_0000;
        p.wreg  = alu[4:0];
        p.instr = alu + 32'h0000_1000;
        p.rt    = alu[9:5];
        return p;
    endfunction

    function automatic vec_t mkv(input logic r, input logic f, input logic iv, input logic o,
                                 input logic [31:0] alu, input logic [3:0] c, input logic ev,
                                 input logic [1:0] eocc, input logic eir, input logic ca,
                                 input logic [31:0] ealu);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = o; v.alu = alu; v.ctrl = c;
        v.ev = ev; v.eocc = eocc; v.eir = eir; v.chk_alu = ca; v.ealu = ealu;
        return v;
    endfunction

    // One clock: drive at negedge, update the queue models at the edge, settle.
    task automatic step(input logic r, input logic f, input logic iv, input logic o, input pay_t p);
        logic acc1, acc0;
        @(negedge clk);
        rst = r; flush = f; in_valid = iv; out_ready = o; drv = p;
        acc1 = iv && (q1.size() < 2) && !f && !r;
        acc0 = iv && (q0.size() == 0 || o) && !f && !r;
        @(posedge clk);
        if (r || f) begin
            q1.delete();
            q0.delete();
        end else begin
            if (q1.size() > 0 && o) void'(q1.pop_front());
            if (acc1) q1.push_back(p);
            if (q0.size() > 0 && o) void'(q0.pop_front());
            if (acc0) q0.push_back(p);
        end
        #1;
    endtask

    task automatic check_models();
        pay_t h;
        chk("s1_valid", ov1, q1.size() > 0);
        chk("s1_occ", occ1, q1.size());
        chk("s1_in_ready", ir1, q1.size() < 2);
        if (q1.size() > 0) begin
            h = q1[0];
            chk("s1_alu", alu1, h.alu);
            chk("s1_wdata", wdata1, h.wdata);
            chk("s1_wreg", wreg1, h.wreg);
            chk("s1_rt", rt1, h.rt);
            chk("s1_instr", instr1, h.instr);
            chk("s1_ctrl", ctrl1, h.ctrl);
            chk("s1_hz", {hmw1, hm2r1, hrw1}, h.ctrl[3:1]);
        end else begin
            chk("s1_bubble", {ctrl1, instr1, hmw1, hm2r1, hrw1}, 39'd0);
        end
        chk("s0_valid", ov0, q0.size() > 0);
        chk("s0_occ", occ0, q0.size());
        chk("s0_in_ready", ir0, (q0.size() == 0) || out_ready);
        if (q0.size() > 0) begin
            h = q0[0];
            chk("s0_alu", alu0, h.alu);
            chk("s0_wdata", wdata0, h.wdata);
            chk("s0_wreg", wreg0, h.wreg);
            chk("s0_rt", rt0, h.rt);
            chk("s0_instr", instr0, h.instr);
            chk("s0_ctrl", ctrl0, h.ctrl);
            chk("s0_hz", {hmw0, hm2r0, hrw0}, h.ctrl[3:1]);
        end else begin
            chk("s0_bubble", {ctrl0, instr0, hmw0, hm2r0, hrw0}, 39'd0);
        end
    endtask

    initial begin
        // rst flush iv ordy alu ctrl | valid occ in_ready chk_alu alu (SKID=1 build)
        vt[0]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'h99, 4'b0110, 1'b0, 2'd0, 1'b1, 1'b1, 32'h0);
        vt[1]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 4'b0110, 1'b1, 2'd1, 1'b1, 1'b1, 32'h10);
        vt[2]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 4'b0110, 1'b1, 2'd1, 1'b1, 1'b1, 32'h20);
        vt[3]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 4'b0110, 1'b1, 2'd1, 1'b1, 1'b1, 32'h30);
        vt[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'b0110, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0);
        vt[5]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'hA,  4'b1010, 1'b1, 2'd1, 1'b1, 1'b1, 32'hA);
        vt[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'hB,  4'b1010, 1'b1, 2'd2, 1'b0, 1'b1, 32'hA);
        vt[7]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'hD,  4'b1010, 1'b1, 2'd2, 1'b0, 1'b1, 32'hA);
        vt[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'b1010, 1'b1, 2'd1, 1'b1, 1'b1, 32'hB);
        vt[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'b1010, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0);
        vt[10] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'h1,  4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 32'h1);
        vt[11] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'h2,  4'b0010, 1'b1, 2'd2, 1'b0, 1'b1, 32'h1);
        vt[12] = mkv(1'b0, 1'b1, 1'b1, 1'b1, 32'hC,  4'b0010, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0);
        vt[13] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'b0010, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0);
        vt[14] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0);
        vt[15] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'h5,  4'b0110, 1'b1, 2'd1, 1'b1, 1'b1, 32'h5);
        vt[16] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'h6,  4'b0110, 1'b1, 2'd2, 1'b0, 1'b1, 32'h5);
        vt[17] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'h7,  4'b0110, 1'b0, 2'd0, 1'b1, 1'b1, 32'h0);
        vt[18] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  4'b0110, 1'b0, 2'd0, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 19; i++) begin
            step(vt[i].rst, vt[i].flush, vt[i].iv, vt[i].ordy, mkpay(vt[i].alu, vt[i].ctrl));
            chk($sformatf("vec%0d_valid", i), ov1, vt[i].ev);
            chk($sformatf("vec%0d_occ", i), occ1, vt[i].eocc);
            chk($sformatf("vec%0d_in_ready", i), ir1, vt[i].eir);
            if (vt[i].chk_alu) chk($sformatf("vec%0d_alu", i), alu1, vt[i].ealu);
            if (!vt[i].ev) chk($sformatf("vec%0d_bubble", i), {ctrl1, instr1, hrw1, hmw1}, 38'd0);
            check_models();
        end

        // Continuous in_valid with out_ready toggling 1,0,1 (SKID=0 mirror check)
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b1, (i % 3) != 1, mkpay(32'h100 + i, 4'b0110));
            check_models();
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, mkpay(32'h0, 4'b1111));
            check_models();
        end

        // Randomized traffic against the queue models
        for (int i = 0; i < 600; i++) begin
            pay_t p;
            p = pay_t'({$urandom, $urandom, $urandom, $urandom});
            step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, p);
            check_models();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register. It replaces the fixed EX->MEM latch with a valid/ready-handshaked stage that has an optional 2-entry skid buffer, flush, and bubble insertion. It sits between any two CPU stages (first use: EX->MEM) and carries the control bits, ALU result, store data, destination register, instruction word and Rt tag. Hazard-unit taps are gated by valid, so bubbles never appear as live writers.

Parameters:
DATA_W, 32, width of alu and wdata payload fields
REG_W, 5, width of register-index fields (wreg, rt)
CTRL_W, 4, control bit vector; bit0 syscall, bit1 regwrite, bit2 mem_to_reg, bit3 mem_write
INSTR_W, 32, instruction word width
SKID, 1, 1 = 2-entry skid buffer (fully registered in_ready); 0 = single entry, in_ready combinational

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries and any same-cycle input
in_valid  in  1  upstream has an entry
in_ready  out  1  stage accepts an entry this cycle
in_ctrl  in  CTRL_W  control bits
in_alu  in  DATA_W  ALU result
in_wdata  in  DATA_W  store data
in_wreg  in  REG_W  destination register
in_instr  in  INSTR_W  instruction word
in_rt  in  REG_W  Rt tag
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes the head
out_ctrl  out  CTRL_W  head control bits, forced 0 when !out_valid
out_alu, out_wdata  out  DATA_W  head payload
out_wreg, out_rt  out  REG_W  head register tags
out_instr  out  INSTR_W  head instruction, 0 when !out_valid (nop)
hz_regwrite, hz_mem_to_reg, hz_mem_write  out  1  hazard taps = out_ctrl bits 1,2,3
occupancy  out  2  entries held (0..2)

Behaviour:
- Accept = in_valid & in_ready & !flush & !rst. Pop = out_valid & out_ready.
- Latency: an entry accepted at edge N is visible on out_* after edge N (1 cycle). No combinational in->out path.
- SKID=1 uses three states:
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> FULL (entry goes to skid); accept & pop -> ONE (main <= input); pop only -> EMPTY.
  - FULL: pop -> ONE (main <= skid); no accept possible.
  - in_ready = (state != FULL), registered-decode, never depends on out_ready.
- SKID=0: main register only. in_ready = !out_valid | out_ready. State EMPTY/ONE; accept & pop in the same cycle keeps ONE with the new data.
- Order is strictly FIFO. Payload of the held main entry must not change while out_valid & !out_ready.
- Flush: at the next edge go to EMPTY, occupancy 0, out_valid 0. Flush wins over a simultaneous accept and pop; that input is dropped. in_ready may stay high during flush.
- Reset: at the edge with rst high, go to EMPTY. Reset values: out_valid 0, all out_* 0, hz_* 0, occupancy 0, in_ready 1. Inputs are ignored while rst is high; reset mid-transfer drops all entries.
- Bubble: when !out_valid, out_ctrl, hz_* and out_instr are 0. The other out_* fields hold their last value (don't-care).
- occupancy: EMPTY 0, ONE 1, FULL 2. Never exceeds 1 when SKID=0.

Test Plan:
- Reset then stream: rst 1 cycle, then feed alu=0x10,0x20,0x30 back-to-back with out_ready=1 -> out_alu 0x10,0x20,0x30 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
- Backpressure (SKID=1): out_ready=0, push A=0xA, B=0xB -> occupancy 2, in_ready 0, out_alu stable at 0xA. Raise out_ready -> A then B are popped, and in_ready returns to 1 the cycle after the first pop.
- Flush with simultaneous accept: stage FULL, then flush=1 with in_valid=1 (alu=0xC) -> next cycle out_valid 0, occupancy 0, and 0xC never appears on the output.
- Bubble gating: hold in_valid=0 with ctrl=4'b1111 on the inputs -> out_ctrl=0, hz_regwrite=hz_mem_write=0, out_instr=0.
- Reset mid-operation: occupancy 2, assert rst with in_valid=1 -> next cycle all outputs 0 and in_ready=1; the previously held entries are never popped.
- SKID=0 build: out_ready toggling 1,0,1 with continuous in_valid -> in_ready mirrors !out_valid|out_ready, no entry lost or duplicated (scoreboard compare).
